control_row_readback: RTL



---
 rtl/control_row_readback_pkg.sv | 33 +++
 rtl/control_row_readback_fb_row_addr_seq.sv | 49 ++++
 rtl/control_row_readback.sv | 132 +++++++++++++
 3 files changed

// File: rtl/control_row_readback_pkg.sv
// Shared framebuffer geometry, address types and readback-specific helpers.
// params/types are the common framebuffer packages; control_row_readback_pkg adds stream helpers.
package params;
    localparam int PIXEL_WIDTH     = 64;
    localparam int BYTES_PER_PIXEL = 4;
    localparam int FB_ROWS         = 32;
endpackage

package types;
    typedef logic [$clog2(params::FB_ROWS)-1:0]         row_addr_t;
    typedef logic [$clog2(params::PIXEL_WIDTH)-1:0]     col_addr_t;
    typedef logic [$clog2(params::BYTES_PER_PIXEL)-1:0] pixel_addr_t;
    typedef logic [$bits(row_addr_t)+$bits(col_addr_t)+$bits(pixel_addr_t)-1:0] fb_addr_t;

    typedef enum logic [2:0] {
        RB_IDLE   = 3'd0,
        RB_HEADER = 3'd1,
        RB_READ   = 3'd2,
        RB_WAIT   = 3'd3,
        RB_SEND   = 3'd4,
        RB_DONE   = 3'd5
    } readback_state_t;
endpackage

package control_row_readback_pkg;
    localparam int ROW_BYTES    = params::PIXEL_WIDTH * params::BYTES_PER_PIXEL;
    localparam int STREAM_BYTES = 1 + ROW_BYTES;

    // Header byte is the row selector zero-extended, matching the readrow command layout.
    function automatic logic [7:0] header_byte(input types::row_addr_t row);
        return 8'(row);
    endfunction
endpackage

// File: rtl/control_row_readback_fb_row_addr_seq.sv
// Column/pixel down-counter walking one framebuffer row from the top byte to {0,0}.
// Shared between the readback transmitter and the readrow command receiver.
module fb_row_addr_seq
    import types::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        advance_i,
    output col_addr_t   col_o,
    output pixel_addr_t pixel_o,
    output logic        last_o
);
    localparam col_addr_t   COL_MAX = col_addr_t'(params::PIXEL_WIDTH - 1);
    localparam pixel_addr_t PIX_MAX = pixel_addr_t'(params::BYTES_PER_PIXEL - 1);

    col_addr_t   col_q, col_d;
    pixel_addr_t pixel_q, pixel_d;

    always_comb begin
        col_d   = col_q;
        pixel_d = pixel_q;
        if (load_i) begin
            col_d   = COL_MAX;
            pixel_d = PIX_MAX;
        end else if (advance_i) begin
            if (pixel_q == '0) begin
                col_d   = col_q - 1'b1;
                pixel_d = PIX_MAX;
            end else begin
                pixel_d = pixel_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            col_q   <= '0;
            pixel_q <= '0;
        end else begin
            col_q   <= col_d;
            pixel_q <= pixel_d;
        end
    end

    assign col_o   = col_q;
    assign pixel_o = pixel_q;
    assign last_o  = (col_q == '0) && (pixel_q == '0);
endmodule

// File: rtl/control_row_readback.sv
// Streams one framebuffer row as {row selector, pixel bytes} over a valid/ready byte port.
// tx_valid/tx_data come straight from registered state, so a stalled byte holds until tx_ready.
module control_row_readback
    import types::*;
    import control_row_readback_pkg::*;
#(
    parameter int RAM_READ_LATENCY = 1,
    parameter int _UNUSED          = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  row_addr_t       row_sel,
    output fb_addr_t        addr,
    output logic            ram_read_enable,
    output logic            ram_access_start,
    input  logic [7:0]      ram_data_in,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic            done,
    output readback_state_t state_dbg
);
    localparam int              LAT_W    = $clog2(RAM_READ_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_READ_LATENCY - 1);

    if ($bits(row_addr_t) > 8) begin : g_row_too_wide
        $error("row_addr_t does not fit in the header byte");
    end
    if (RAM_READ_LATENCY < 1 || RAM_READ_LATENCY > 4) begin : g_bad_latency
        $error("RAM_READ_LATENCY must be in 1..4");
    end
    if (_UNUSED < 0) begin : g_bad_unused
        $error("_UNUSED must be non-negative");
    end

    readback_state_t   state_q, state_d;
    row_addr_t         row_q, row_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              toggle_q, toggle_d;

    logic        seq_load, seq_advance, seq_last;
    col_addr_t   seq_col;
    pixel_addr_t seq_pixel;

    fb_row_addr_seq u_addr_seq (
        .clk_i     (clk),
        .rst_ni    (reset),
        .load_i    (seq_load),
        .advance_i (seq_advance),
        .col_o     (seq_col),
        .pixel_o   (seq_pixel),
        .last_o    (seq_last)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        tx_data_d   = tx_data_q;
        lat_d       = lat_q;
        toggle_d    = toggle_q;
        seq_load    = 1'b0;
        seq_advance = 1'b0;
        case (state_q)
            RB_IDLE: begin
                if (start) begin
                    row_d     = row_sel;
                    tx_data_d = header_byte(row_sel);
                    seq_load  = 1'b1;
                    state_d   = RB_HEADER;
                end
            end
            RB_HEADER: begin
                if (tx_ready) state_d = RB_READ;
            end
            RB_READ: begin
                toggle_d = ~toggle_q;
                lat_d    = '0;
                state_d  = RB_WAIT;
            end
            RB_WAIT: begin
                // Data is only trusted on the final latency cycle.
                if (lat_q == LAT_LAST) begin
                    tx_data_d = ram_data_in;
                    state_d   = RB_SEND;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RB_SEND: begin
                if (tx_ready) begin
                    if (seq_last) begin
                        state_d = RB_DONE;
                    end else begin
                        seq_advance = 1'b1;
                        state_d     = RB_READ;
                    end
                end
            end
            RB_DONE: state_d = RB_IDLE;
            default: state_d = RB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RB_IDLE;
            row_q     <= '0;
            tx_data_q <= '0;
            lat_q     <= '0;
            toggle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            tx_data_q <= tx_data_d;
            lat_q     <= lat_d;
            toggle_q  <= toggle_d;
        end
    end

    // Address is held through WAIT so RAMs with multi-cycle latency see a stable address.
    assign addr             = {row_q, seq_col, seq_pixel};
    assign ram_read_enable  = (state_q == RB_READ);
    assign ram_access_start = toggle_q;
    assign tx_data          = tx_data_q;
    assign tx_valid         = (state_q == RB_HEADER) || (state_q == RB_SEND);
    assign busy             = (state_q != RB_IDLE);
    assign done             = (state_q == RB_DONE);
    assign state_dbg        = state_q;
endmodule
